// File: rtl/timer60_ctrl.sv
// timer60_ctrl: 1 Hz prescaler, start/pause/clear FSM, BCD 00..59, digit scan.
// Optional build macro STOP_AT_59_EN: hold at 59 in DONE instead of wrapping.
module timer60_ctrl #(
  parameter int CLK_HZ   = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] digit_nibble,
  output logic [1:0] digit_en,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       wrap,
  output logic       done
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);

`ifdef STOP_AT_59_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
`endif

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] scan_q;
  logic          sel_q;
  logic          ss_s1, ss_s2, ss_prev;
  logic          cl_s1, cl_s2;
  logic          rise;
  logic          tick;

  assign rise = ss_s2 & ~ss_prev;
  assign tick = (state_q == RUN) && (pre_q == PMAX);

  // Two-flop synchronizers for both buttons plus edge history for start_stop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_s1   <= 1'b0;
      ss_s2   <= 1'b0;
      ss_prev <= 1'b0;
      cl_s1   <= 1'b0;
      cl_s2   <= 1'b0;
    end else begin
      ss_s1   <= start_stop;
      ss_s2   <= ss_s1;
      ss_prev <= ss_s2;
      cl_s1   <= clear;
      cl_s2   <= cl_s1;
    end
  end

  // Timer registers: state, prescaler, BCD digits, wrap pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next state, prescaler advance and BCD increment; clear overrides all
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    wrap_d  = 1'b0;
    if (cl_s2) begin
      state_d = IDLE;
      pre_d   = '0;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pre_d = '0;
          if (rise) state_d = RUN;
        end
        RUN: begin
          pre_d = tick ? '0 : pre_q + PW'(1);
          if (rise) state_d = PAUSE;
        end
        PAUSE: begin
          if (rise) state_d = RUN;
        end
`ifdef STOP_AT_59_EN
        DONE: begin
          pre_d = '0;
        end
`endif
        default: state_d = IDLE;
      endcase
      if (tick) begin
        if (ones_q == 4'd9) begin
          if (tens_q == 4'd5) begin
`ifdef STOP_AT_59_EN
            state_d = DONE;
`else
            ones_d = 4'd0;
            tens_d = 4'd0;
            wrap_d = 1'b1;
`endif
          end else begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
          end
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end
  end

  // Free-running scan counter; select flips at each terminal count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q <= '0;
      sel_q  <= 1'b0;
    end else if (scan_q == SMAX) begin
      scan_q <= '0;
      sel_q  <= ~sel_q;
    end else begin
      scan_q <= scan_q + SW'(1);
    end
  end

  assign ones         = ones_q;
  assign tens         = tens_q;
  assign wrap         = wrap_q;
  assign running      = (state_q == RUN);
  assign digit_en     = sel_q ? 2'b10 : 2'b01;
  assign digit_nibble = sel_q ? tens_q : ones_q;

`ifdef STOP_AT_59_EN
  assign done = (state_q == DONE);
`else
  assign done = 1'b0;
`endif

endmodule
